// File: rtl/decimation_sequencer_if.sv
// decimation_sequencer_if: control, accumulator and sample handshake signals of the decimation sequencer
interface decimation_sequencer_if #(parameter int CNT_W = 16, parameter int DISC_W = 4);
    logic              enable;
    logic [CNT_W-1:0]  osr;
    logic [DISC_W-1:0] discard;
    logic [CNT_W-1:0]  acc_count;
    logic              acc_clear;
    logic              acc_dump;
    logic [CNT_W-1:0]  sample;
    logic              sample_valid;
    logic              sample_ready;
    logic              overrun;
    logic              busy;
    modport master (output enable, osr, discard, acc_count, sample_ready,
                    input  acc_clear, acc_dump, sample, sample_valid, overrun, busy);
    modport slave  (input  enable, osr, discard, acc_count, sample_ready,
                    output acc_clear, acc_dump, sample, sample_valid, overrun, busy);
endinterface

// File: rtl/decimation_sequencer.sv
// decimation_sequencer: frames the ones-counting accumulator, drops warm-up frames and hands frame counts out on valid/ready
module decimation_sequencer #(
    parameter int CNT_W  = 16,
    parameter int DISC_W = 4
) (
    input logic                   clk,
    input logic                   reset,
    decimation_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  ph_q, ph_d, osr_q, osr_d, sample_q, sample_d;
    logic [DISC_W-1:0] disc_q, disc_d;
    logic              valid_q, valid_d, ovr_q, ovr_d, dump;
    // dump is decoded from registers only so it carries no input-to-output path
    assign dump             = (state_q != IDLE) && (ph_q == osr_q - CNT_W'(1));
    assign bus.acc_dump     = dump;
    assign bus.acc_clear    = (state_q == IDLE) || dump;
    assign bus.busy         = state_q != IDLE;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.overrun      = ovr_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ph_q     <= '0;
            osr_q    <= CNT_W'(2);
            disc_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            osr_q    <= osr_d;
            disc_q   <= disc_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        ph_d     = dump ? '0 : ph_q + CNT_W'(1);
        osr_d    = osr_q;
        disc_d   = disc_q;
        sample_d = sample_q;
        valid_d  = valid_q && !bus.sample_ready;
        ovr_d    = ovr_q;
        if (state_q == IDLE) begin
            ph_d = '0;
            if (bus.enable) begin
                osr_d   = bus.osr < CNT_W'(2) ? CNT_W'(2) : bus.osr;
                disc_d  = bus.discard;
                ovr_d   = 1'b0;
                state_d = bus.discard != '0 ? WARMUP : RUN;
            end
        end else if (!bus.enable) begin
            state_d = IDLE;
        end else if (dump && state_q == WARMUP) begin
            disc_d  = disc_q - DISC_W'(1);
            state_d = disc_q == DISC_W'(1) ? RUN : WARMUP;
        end else if (dump) begin
            // newest sample wins; overrun only when the old one was not taken on this edge
            sample_d = bus.acc_count;
            valid_d  = 1'b1;
            ovr_d    = ovr_q || (valid_q && !bus.sample_ready);
        end
    end
endmodule
